// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and types for the fetch stage
// Contents: NOP encoding, fetch-buffer entry width, fetch FSM state codes.
// IFETCH_MISALIGN_CHECK_EN adds a misalign flag bit to each buffer entry.
package cpu_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

`ifdef IFETCH_MISALIGN_CHECK_EN
    // {misalign, pc, inst}
    localparam int ENTRY_W = 65;
`else
    // {pc, inst}
    localparam int ENTRY_W = 64;
`endif

    typedef logic [0:0] fetch_state_t;
    localparam fetch_state_t FS_BOOT = 1'b0;
    localparam fetch_state_t FS_RUN  = 1'b1;

endpackage

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - fetch buffer, circular FIFO with synchronous clear
// Ports: clk, rst_n (async active-low), clr (sync clear), push/push_data,
//        pop, head_data (entry at read pointer), full, empty, count.
module if_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // Clear wins over any same-cycle push or pop.
    assign do_push = push & ~clr;
    assign do_pop  = pop & ~empty & ~clr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Depth is a power of two, so pointer overflow is the wrap.
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: empty masks the head at the consumer.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign count     = count_q;

endmodule

// File: rtl/ifetch_stage.sv
// rtl/ifetch_stage.sv - instruction fetch stage with decoupling buffer
// Ports: clk, rst_n (async active-low); pc in, pc_stall out (PC hold);
//        imem_addr/imem_req out, imem_rdata in (one-cycle latency);
//        flush in (redirect); id_valid/id_ready/id_inst/id_pc decode side.
// IFETCH_MISALIGN_CHECK_EN adds output id_misalign and NOP substitution.
module ifetch_stage
    import cpu_pkg::*;
#(
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    output logic        pc_stall,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        flush,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
`ifdef IFETCH_MISALIGN_CHECK_EN
    output logic [31:0] id_pc,
    output logic        id_misalign
`else
    output logic [31:0] id_pc
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t       state_q, state_d;
    logic               inflight_q, inflight_d;
    logic [31:0]        inflight_pc_q, inflight_pc_d;
    logic [CW-1:0]      fifo_count;
    logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [ENTRY_W-1:0] push_entry, head_entry;
    logic [CW:0]        committed;

    // A pop this cycle frees a slot for a request issued this cycle.
    assign fifo_pop  = ~fifo_empty & id_ready & ~flush;
    assign committed = {1'b0, fifo_count} + (CW+1)'(inflight_q) - (CW+1)'(fifo_pop);

    assign imem_req  = (state_q == FS_RUN) & ~flush & (committed < (CW+1)'(FIFO_DEPTH));
    assign imem_addr = pc;
    // During a redirect the PC must load the new target.
    assign pc_stall  = flush ? (state_q == FS_BOOT) : ~imem_req;

    // Returning data is dropped by a flush in its arrival cycle.
    assign fifo_push = inflight_q & ~flush & (~fifo_full | fifo_pop);

`ifdef IFETCH_MISALIGN_CHECK_EN
    logic inflight_mis_q, inflight_mis_d;

    assign push_entry  = {inflight_mis_q, inflight_pc_q,
                          inflight_mis_q ? NOP_INST : imem_rdata};
    assign id_misalign = ~fifo_empty & head_entry[64];

    always_comb begin
        inflight_mis_d = inflight_mis_q;
        if (imem_req) inflight_mis_d = (pc[1:0] != 2'b00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inflight_mis_q <= 1'b0;
        else        inflight_mis_q <= inflight_mis_d;
    end
`else
    assign push_entry = {inflight_pc_q, imem_rdata};
`endif

    always_comb begin
        state_d       = FS_RUN;
        inflight_d    = imem_req;
        inflight_pc_d = imem_req ? pc : inflight_pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FS_BOOT;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
        end else begin
            state_q       <= state_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    if_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (flush),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // No bypass: decode only ever sees buffered entries.
    assign id_valid = ~fifo_empty;
    assign id_inst  = fifo_empty ? 32'h0 : head_entry[31:0];
    assign id_pc    = fifo_empty ? RESET_PC : head_entry[63:32];

endmodule

// File: tb/tb_ifetch_stage.sv
// tb/tb_ifetch_stage.sv - self-checking bench for ifetch_stage
module tb_ifetch_stage;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n, flush, id_ready;
    logic [31:0] pc, imem_rdata;
    logic        pc_stall, imem_req, id_valid;
    logic [31:0] imem_addr, id_inst, id_pc;
`ifdef IFETCH_MISALIGN_CHECK_EN
    logic        id_misalign;
`endif

    always #5 clk = ~clk;

    ifetch_stage #(.FIFO_DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc         (pc),
        .pc_stall   (pc_stall),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_rdata (imem_rdata),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_inst    (id_inst),
`ifdef IFETCH_MISALIGN_CHECK_EN
        .id_pc      (id_pc),
        .id_misalign(id_misalign)
`else
        .id_pc      (id_pc)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        mis;
    } ent_t;

    ent_t        mq[$];
    int          m_pend;
    logic [31:0] m_pend_pc;
    bit          m_boot;
    logic [31:0] flush_target;
    logic        e_valid, e_req, e_stall, e_pop, e_mis;
    logic [31:0] e_pc, e_inst;
    int          n_cmp, n_fail, cyc;
    logic [98:0] obs, expv;

    function automatic logic [31:0] mem_fn(logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1234};
    endfunction

    function automatic ent_t make_entry(logic [31:0] a);
        ent_t e;
        e.pc   = a;
        e.inst = mem_fn(a);
        e.mis  = 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
        if (a[1:0] != 2'b00) begin
            e.inst = NOP;
            e.mis  = 1'b1;
        end
`endif
        return e;
    endfunction

    // Expected outputs for the current cycle from the queue-level model.
    task model_eval();
        e_valid = (mq.size() != 0);
        e_pc    = e_valid ? mq[0].pc : RESET_PC;
        e_inst  = e_valid ? mq[0].inst : 32'h0;
        e_mis   = e_valid ? mq[0].mis : 1'b0;
        e_pop   = e_valid && id_ready && !flush;
        e_req   = !m_boot && !flush && ((mq.size() + m_pend - (e_pop ? 1 : 0)) < DEPTH);
        e_stall = m_boot ? 1'b1 : (flush ? 1'b0 : !e_req);
    endtask

    // Advance one clock: model bookkeeping, then PC register and memory.
    task model_step();
        logic [31:0] old_pc;
        @(posedge clk);
        old_pc = pc;
        if (flush) begin
            mq.delete();
            m_pend = 0;
        end else begin
            if (e_pop) void'(mq.pop_front());
            if (m_pend != 0) mq.push_back(make_entry(m_pend_pc));
            m_pend    = e_req ? 1 : 0;
            m_pend_pc = old_pc;
        end
        m_boot = 1'b0;
        cyc++;
        #1;
        pc         = flush ? flush_target : (e_stall ? old_pc : old_pc + 32'd4);
        imem_rdata = (m_pend != 0) ? mem_fn(m_pend_pc) : $urandom();
    endtask

    task reset_low();
        rst_n    = 1'b0;
        flush    = 1'b0;
        id_ready = 1'b0;
        pc       = RESET_PC;
        mq.delete();
        m_pend   = 0;
        m_boot   = 1'b1;
    endtask

    task reset_release();
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        imem_rdata = $urandom();
        cyc        = 0;
    endtask

    task test_reset();
        reset_low();
        imem_rdata = $urandom();
        #1;
        n_cmp++;
        if ({id_valid, imem_req, pc_stall, id_inst, id_pc} !== {1'b0, 1'b0, 1'b1, 32'h0, RESET_PC}) begin
            n_fail++;
            $display("FAIL reset_values: got %h want %h",
                     {id_valid, imem_req, pc_stall, id_inst, id_pc}, {1'b0, 1'b0, 1'b1, 32'h0, RESET_PC});
        end
        reset_release();
    endtask

    task test_latency();
        int first_valid;
        logic [31:0] seen[$];
        first_valid = -1;
        for (int i = 0; i < 10; i++) begin
            id_ready = 1'b1;
            flush    = 1'b0;
            #1;
            model_eval();
            if (id_valid === 1'b1 && first_valid < 0) first_valid = cyc;
            if (id_valid === 1'b1) seen.push_back(id_pc);
            obs  = {id_valid, imem_req, pc_stall, imem_addr, id_pc, id_inst};
            expv = {e_valid, e_req, e_stall, pc, e_pc, e_inst};
            n_cmp++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL latency cyc %0d: got %h want %h", cyc, obs, expv);
            end
            model_step();
        end
        n_cmp++;
        if (first_valid != 3) begin
            n_fail++;
            $display("FAIL first_valid_cycle: got %0d want 3", first_valid);
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (seen.size() <= k || seen[k] !== 32'(4 * k)) begin
                n_fail++;
                $display("FAIL in_order_pc[%0d]: got %h want %h", k,
                         (seen.size() > k) ? seen[k] : 32'hx, 32'(4 * k));
            end
        end
    endtask

    task test_backpressure();
        for (int i = 0; i < 12; i++) begin
            id_ready = (i >= 6);
            flush    = 1'b0;
            #1;
            model_eval();
            obs  = {id_valid, imem_req, pc_stall, imem_addr, id_pc, id_inst};
            expv = {e_valid, e_req, e_stall, pc, e_pc, e_inst};
            n_cmp++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL backpressure cyc %0d: got %h want %h", cyc, obs, expv);
            end
            model_step();
        end
    endtask

    task test_full_one_pop();
        int pops;
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            id_ready = (i == 4);
            flush    = 1'b0;
            #1;
            model_eval();
            if (id_valid === 1'b1 && id_ready) pops++;
            obs  = {id_valid, imem_req, pc_stall, imem_addr, id_pc, id_inst};
            expv = {e_valid, e_req, e_stall, pc, e_pc, e_inst};
            n_cmp++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL full_one_pop cyc %0d: got %h want %h", cyc, obs, expv);
            end
            model_step();
        end
        n_cmp++;
        if (pops != 1) begin
            n_fail++;
            $display("FAIL full_pop_count: got %0d want 1", pops);
        end
    endtask

    task test_flush();
        logic [31:0] first_pc;
        bit          got;
        got = 1'b0;
        first_pc = 32'hx;
        flush_target = 32'h0000_0100;
        // full, one pop, then flush while one entry is buffered and one in flight
        for (int i = 0; i < 12; i++) begin
            id_ready = (i >= 3);
            flush    = (i == 4);
            #1;
            model_eval();
            if (i > 4 && id_valid === 1'b1 && !got) begin
                got = 1'b1;
                first_pc = id_pc;
            end
            obs  = {id_valid, imem_req, pc_stall, imem_addr, id_pc, id_inst};
            expv = {e_valid, e_req, e_stall, pc, e_pc, e_inst};
            n_cmp++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL flush cyc %0d: got %h want %h", cyc, obs, expv);
            end
            model_step();
        end
        n_cmp++;
        if (first_pc !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL flush_redirect_pc: got %h want %h", first_pc, 32'h0000_0100);
        end
    endtask

    task test_random();
        for (int i = 0; i < 400; i++) begin
            id_ready     = ($urandom_range(0, 2) != 0);
            flush        = ($urandom_range(0, 15) == 0);
            flush_target = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            #1;
            model_eval();
            obs  = {id_valid, imem_req, pc_stall, imem_addr, id_pc, id_inst};
            expv = {e_valid, e_req, e_stall, pc, e_pc, e_inst};
            n_cmp++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h want %h", cyc, obs, expv);
            end
            model_step();
        end
    endtask

    task test_reset_mid_run();
        for (int i = 0; i < 3; i++) begin
            id_ready = 1'b0;
            flush    = 1'b0;
            #1;
            model_eval();
            model_step();
        end
        reset_low();
        #1;
        n_cmp++;
        if ({id_valid, imem_req, pc_stall, id_inst, id_pc} !== {1'b0, 1'b0, 1'b1, 32'h0, RESET_PC}) begin
            n_fail++;
            $display("FAIL midrun_reset_values: got %h want %h",
                     {id_valid, imem_req, pc_stall, id_inst, id_pc}, {1'b0, 1'b0, 1'b1, 32'h0, RESET_PC});
        end
        reset_release();
        for (int i = 0; i < 8; i++) begin
            id_ready = 1'b1;
            flush    = 1'b0;
            #1;
            model_eval();
            if (i < 2) begin
                n_cmp++;
                if (imem_req !== (i == 1)) begin
                    n_fail++;
                    $display("FAIL boot_req cyc %0d: got %b want %b", i, imem_req, (i == 1));
                end
            end
            obs  = {id_valid, imem_req, pc_stall, imem_addr, id_pc, id_inst};
            expv = {e_valid, e_req, e_stall, pc, e_pc, e_inst};
            n_cmp++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL after_reset cyc %0d: got %h want %h", cyc, obs, expv);
            end
            model_step();
        end
    endtask

`ifdef IFETCH_MISALIGN_CHECK_EN
    task test_misalign();
        bit got;
        got = 1'b0;
        flush_target = 32'h0000_0006;
        for (int i = 0; i < 8; i++) begin
            id_ready = 1'b0;
            flush    = (i == 0);
            #1;
            model_eval();
            if (i > 0 && id_valid === 1'b1 && !got) begin
                got = 1'b1;
                n_cmp++;
                if ({id_pc, id_inst, id_misalign} !== {32'h6, NOP, 1'b1}) begin
                    n_fail++;
                    $display("FAIL misalign_entry: got %h want %h",
                             {id_pc, id_inst, id_misalign}, {32'h6, NOP, 1'b1});
                end
            end
            n_cmp++;
            if ({id_valid, id_inst, id_misalign} !== {e_valid, e_inst, e_mis}) begin
                n_fail++;
                $display("FAIL misalign cyc %0d: got %h want %h", cyc,
                         {id_valid, id_inst, id_misalign}, {e_valid, e_inst, e_mis});
            end
            model_step();
        end
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL misalign_timeout: got no entry want entry");
        end
    endtask
`endif

    initial begin
        n_cmp        = 0;
        n_fail       = 0;
        cyc          = 0;
        flush_target = 32'h0;
        m_pend_pc    = 32'h0;
        test_reset();
        test_latency();
        test_backpressure();
        test_full_one_pop();
        test_flush();
        test_random();
        test_reset_mid_run();
`ifdef IFETCH_MISALIGN_CHECK_EN
        test_misalign();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
